// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates the register-file write port between ALU/MUL/DIV/LSU with starvation aging.
// Define WB_ARB_RR_EN to replace fixed LSU>DIV>MUL>ALU priority with a rotating round-robin.
module wb_arbiter #(
   parameter int XLEN                = 32,
   parameter int REG_FILE_ADDR_WIDTH = 5,
   parameter int STARVE_LIMIT        = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alu_valid,
   input  logic                           mul_valid,
   input  logic                           div_valid,
   input  logic                           lsu_valid,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] alu_rd_addr,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] mul_rd_addr,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] div_rd_addr,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] lsu_rd_addr,
   input  logic [XLEN-1:0]                alu_data,
   input  logic [XLEN-1:0]                mul_data,
   input  logic [XLEN-1:0]                div_data,
   input  logic [XLEN-1:0]                lsu_data,
   output logic                           alu_ready,
   output logic                           mul_ready,
   output logic                           div_ready,
   output logic                           lsu_ready,
   output logic [XLEN-1:0]                exu_wb_data,
   output logic [REG_FILE_ADDR_WIDTH-1:0] exu_wb_rd_addr,
   output logic                           exu_wb_rd_wr_en,
   output logic                           wb_stall
);

   localparam int         N     = 4;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [N-1:0]                   req;
   logic [N-1:0]                   starved;
   logic [N-1:0]                   cand;
   logic [N-1:0]                   gnt;
   logic [1:0]                     gnt_idx;
   logic [3:0]                     age [N];
   logic [REG_FILE_ADDR_WIDTH-1:0] addr_a [N];
   logic [XLEN-1:0]                data_a [N];
   logic                           xfer;

   // Source index order doubles as fixed priority: higher index wins.
   assign req       = {lsu_valid, div_valid, mul_valid, alu_valid};
   assign addr_a[0] = alu_rd_addr;
   assign addr_a[1] = mul_rd_addr;
   assign addr_a[2] = div_rd_addr;
   assign addr_a[3] = lsu_rd_addr;
   assign data_a[0] = alu_data;
   assign data_a[1] = mul_data;
   assign data_a[2] = div_data;
   assign data_a[3] = lsu_data;

   always_comb begin
      starved = '0;
      for (int i = 0; i < N; i++)
         starved[i] = req[i] && (age[i] == LIMIT);
      cand = (|starved) ? starved : req;
   end

`ifdef WB_ARB_RR_EN
   logic [1:0] last_grant;
   logic [1:0] rr_idx;

   // Scan from lowest to highest rotated priority so the slot right after last_grant wins.
   always_comb begin
      gnt_idx = '0;
      rr_idx  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         rr_idx = last_grant + 2'(k + 1);
         if (cand[rr_idx])
            gnt_idx = rr_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 2'd0;
      else if (xfer)
         last_grant <= gnt_idx;
   end
`else
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N; i++)
         if (cand[i])
            gnt_idx = 2'(i);
   end
`endif

   assign gnt       = (rst || cand == '0) ? '0 : (4'b0001 << gnt_idx);
   assign xfer      = |gnt;
   assign alu_ready = gnt[0];
   assign mul_ready = gnt[1];
   assign div_ready = gnt[2];
   assign lsu_ready = gnt[3];
   assign wb_stall  = !rst && |(req & ~gnt);

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst || !req[i] || gnt[i])
            age[i] <= '0;
         else if (age[i] != LIMIT)
            age[i] <= age[i] + 4'd1;
      end
   end

   // Writeback register stage: one cycle from grant to the IDU1 port; x0 grants never write.
   always_ff @(posedge clk) begin
      if (rst) begin
         exu_wb_rd_wr_en <= 1'b0;
         exu_wb_rd_addr  <= '0;
         exu_wb_data     <= '0;
      end else begin
         exu_wb_rd_wr_en <= xfer && (addr_a[gnt_idx] != '0);
         if (xfer) begin
            exu_wb_rd_addr <= addr_a[gnt_idx];
            exu_wb_data    <= data_a[gnt_idx];
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic against a rank-based model.
module tb_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int LIMIT = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      v;
   logic [AW-1:0]   ra [4];
   logic [XLEN-1:0] rd [4];
   logic            alu_ready, mul_ready, div_ready, lsu_ready, wb_stall, wr_en;
   logic [XLEN-1:0] wb_data;
   logic [AW-1:0]   wb_addr;
   logic [3:0]      rdy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: per-source denied-cycle counts, round-robin pointer, expected port registers.
   int              wait_cnt [4];
   int              ptr;
   logic            m_wr;
   logic [AW-1:0]   m_addr;
   logic [XLEN-1:0] m_data;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XLEN), .REG_FILE_ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(v[0]), .mul_valid(v[1]), .div_valid(v[2]), .lsu_valid(v[3]),
      .alu_rd_addr(ra[0]), .mul_rd_addr(ra[1]), .div_rd_addr(ra[2]), .lsu_rd_addr(ra[3]),
      .alu_data(rd[0]), .mul_data(rd[1]), .div_data(rd[2]), .lsu_data(rd[3]),
      .alu_ready(alu_ready), .mul_ready(mul_ready), .div_ready(div_ready), .lsu_ready(lsu_ready),
      .exu_wb_data(wb_data), .exu_wb_rd_addr(wb_addr), .exu_wb_rd_wr_en(wr_en),
      .wb_stall(wb_stall)
   );

   assign rdy = {lsu_ready, div_ready, mul_ready, alu_ready};

   // Winner = eligible source with the highest rank; starved sources alone are eligible if any exist.
   function automatic int model_pick();
      int best = -1;
      int best_rank = -1;
      int rank;
      bit any_st = 1'b0;
      if (rst) return -1;
      for (int i = 0; i < 4; i++)
         if (v[i] && wait_cnt[i] >= LIMIT) any_st = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (!v[i] || (any_st && wait_cnt[i] < LIMIT)) continue;
`ifdef WB_ARB_RR_EN
         rank = 3 - ((i - ptr + 3) % 4);
`else
         rank = i;
`endif
         if (rank > best_rank) begin
            best_rank = rank;
            best = i;
         end
      end
      return best;
   endfunction

   function automatic logic [3:0] onehot(input int g);
      return (g < 0) ? 4'b0000 : 4'(1 << g);
   endfunction

   function automatic logic stall_of(input int g);
      if (rst) return 1'b0;
      for (int i = 0; i < 4; i++)
         if (v[i] && i != g) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_clock(input int g);
      if (rst) begin
         for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
         ptr = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
         return;
      end
      for (int i = 0; i < 4; i++)
         if (v[i] && i != g) wait_cnt[i] = (wait_cnt[i] < LIMIT) ? wait_cnt[i] + 1 : LIMIT;
         else wait_cnt[i] = 0;
      if (g >= 0) begin
         m_wr = (ra[g] != '0); m_addr = ra[g]; m_data = rd[g]; ptr = g;
      end else begin
         m_wr = 1'b0;
      end
   endfunction

   task automatic advance(input int g);
      model_clock(g);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      v = 4'hF;
      for (int i = 0; i < 4; i++) begin
         ra[i] = AW'(i + 1);
         rd[i] = 32'hA0 + 32'(i);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", rdy); end
         n_checks++;
         if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", wb_stall); end
         n_checks++;
         if ({wr_en, wb_addr, wb_data} !== '0)
            begin n_fail++; $display("FAIL reset_outputs: got en=%b rd=%0d data=%h want all 0", wr_en, wb_addr, wb_data); end
         advance(-1);
      end
      rst = 1'b0;
      v = '0;
   endtask

   task automatic test_single();
      v = '0; v[0] = 1'b1; ra[0] = 5'd5; rd[0] = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if (rdy !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", rdy); end
      n_checks++;
      if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL single_stall: got %b want 0", wb_stall); end
      advance(model_pick());
      v[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({wr_en, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
         begin n_fail++; $display("FAIL single_wb: got en=%b rd=%0d data=%h want en=1 rd=5 data=deadbeef", wr_en, wb_addr, wb_data); end
      advance(model_pick());
      @(negedge clk);
      n_checks++;
      if ({wr_en, wb_addr} !== {1'b0, 5'd5})
         begin n_fail++; $display("FAIL single_after: got en=%b rd=%0d want en=0 rd=5", wr_en, wb_addr); end
      advance(model_pick());
   endtask

   task automatic test_contention();
      v = '0;
      v[1] = 1'b1; ra[1] = 5'd3; rd[1] = 32'h11;
      v[3] = 1'b1; ra[3] = 5'd4; rd[3] = 32'h22;
      @(negedge clk);
      n_checks++;
      if (rdy !== 4'b1000) begin n_fail++; $display("FAIL contend_first: got %b want 1000", rdy); end
      n_checks++;
      if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL contend_stall: got %b want 1", wb_stall); end
      advance(model_pick());
      v[3] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rdy !== 4'b0010) begin n_fail++; $display("FAIL contend_second: got %b want 0010", rdy); end
      n_checks++;
      if ({wr_en, wb_addr, wb_data} !== {1'b1, 5'd4, 32'h22})
         begin n_fail++; $display("FAIL contend_wb1: got en=%b rd=%0d data=%h want en=1 rd=4 data=22", wr_en, wb_addr, wb_data); end
      advance(model_pick());
      v[1] = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({wr_en, wb_addr, wb_data} !== {1'b1, 5'd3, 32'h11})
         begin n_fail++; $display("FAIL contend_wb2: got en=%b rd=%0d data=%h want en=1 rd=3 data=11", wr_en, wb_addr, wb_data); end
      advance(model_pick());
   endtask

   // ALU stays valid while LSU and DIV take turns issuing fresh single requests.
   task automatic test_starvation();
      int t = 0;
      logic [3:0] want;
      v = '0;
      v[0] = 1'b1; ra[0] = 5'd7; rd[0] = 32'hA11CE;
      v[3] = 1'b1; ra[3] = 5'd9; rd[3] = $urandom;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         want = (c == 4) ? 4'b0001 : ((t == 1) ? 4'b0100 : 4'b1000);
         n_checks++;
         if (rdy !== want) begin n_fail++; $display("FAIL starve_c%0d: got %b want %b", c, rdy, want); end
         n_checks++;
         if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall_c%0d: got %b want 1", c, wb_stall); end
         advance(model_pick());
         if (c == 4) begin
            ra[0] = 5'd8; rd[0] = $urandom;
         end else begin
            v[3 - t] = 1'b0;
            t = 1 - t;
            v[3 - t] = 1'b1; ra[3 - t] = AW'($urandom_range(1, 31)); rd[3 - t] = $urandom;
         end
      end
      v = '0;
      advance(model_pick());
   endtask

   task automatic test_x0();
      v = '0; v[2] = 1'b1; ra[2] = 5'd0; rd[2] = 32'h55;
      @(negedge clk);
      n_checks++;
      if (rdy !== 4'b0100) begin n_fail++; $display("FAIL x0_ready: got %b want 0100", rdy); end
      advance(model_pick());
      v[2] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_wr_en: got %b want 0", wr_en); end
      advance(model_pick());
   endtask

   task automatic test_idle();
      v = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if ({rdy, wb_stall, wr_en} !== 6'b0)
            begin n_fail++; $display("FAIL idle_c%0d: got rdy=%b stall=%b en=%b want all 0", c, rdy, wb_stall, wr_en); end
         advance(model_pick());
      end
   endtask

`ifdef WB_ARB_RR_EN
   task automatic test_rr();
      int want;
      v = 4'hF;
      for (int i = 0; i < 4; i++) begin ra[i] = AW'(i + 1); rd[i] = $urandom; end
      for (int c = 0; c < 8; c++) begin
         want = (c + 1) % 4;
         @(negedge clk);
         n_checks++;
         if (rdy !== 4'(1 << want)) begin n_fail++; $display("FAIL rr_order_c%0d: got %b want %b", c, rdy, 4'(1 << want)); end
         n_checks++;
         if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL rr_stall_c%0d: got %b want 1", c, wb_stall); end
         advance(model_pick());
         ra[want] = AW'($urandom_range(1, 31)); rd[want] = $urandom;
      end
      v = '0;
      advance(model_pick());
   endtask
`endif

   task automatic test_random();
      int g;
      v = '0;
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         @(negedge clk);
         g = model_pick();
         n_checks++;
         if (rdy !== onehot(g)) begin n_fail++; $display("FAIL rand_ready_c%0d: got %b want %b", c, rdy, onehot(g)); end
         n_checks++;
         if (wb_stall !== stall_of(g)) begin n_fail++; $display("FAIL rand_stall_c%0d: got %b want %b", c, wb_stall, stall_of(g)); end
         n_checks++;
         if ({wr_en, wb_addr, wb_data} !== {m_wr, m_addr, m_data})
            begin n_fail++; $display("FAIL rand_wb_c%0d: got en=%b rd=%0d data=%h want en=%b rd=%0d data=%h",
                                      c, wr_en, wb_addr, wb_data, m_wr, m_addr, m_data); end
         advance(g);
         for (int i = 0; i < 4; i++) begin
            if (i == g || (!v[i] && $urandom_range(0, 2) == 0)) begin
               v[i]  = (i == g) ? 1'($urandom_range(0, 1)) : 1'b1;
               ra[i] = AW'($urandom_range(0, 31));
               rd[i] = $urandom;
            end
         end
      end
      rst = 1'b0;
      v = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      v = '0;
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      ptr = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
      test_reset();
`ifdef WB_ARB_RR_EN
      test_rr();
`endif
      test_single();
`ifndef WB_ARB_RR_EN
      test_contention();
      test_starvation();
`endif
      test_x0();
      test_idle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Arbitrates the single register-file write port between the four EXU result sources: ALU, MUL, DIV and LSU.
- Drives the registered exu_wb_data / exu_wb_rd_addr / exu_wb_rd_wr_en bundle consumed by IDU1 for register-file write and WB forwarding.
- Uses fixed priority with starvation aging.
- Raises wb_stall toward the pipe_stall logic whenever a result is held off the port.

Parameters:
- XLEN, 32, datapath width.
- REG_FILE_ADDR_WIDTH, 5, register address width.
- STARVE_LIMIT, 4, consecutive denied cycles after which a requester is promoted to top priority (range 1..15).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- alu_valid, mul_valid, div_valid, lsu_valid  input  1 each  source has a result pending
- alu_rd_addr, mul_rd_addr, div_rd_addr, lsu_rd_addr  input  REG_FILE_ADDR_WIDTH each  destination register
- alu_data, mul_data, div_data, lsu_data  input  XLEN each  result value
- alu_ready, mul_ready, div_ready, lsu_ready  output  1 each  grant this cycle (combinational from valids and state)
- exu_wb_data  output  XLEN  registered writeback data
- exu_wb_rd_addr  output  REG_FILE_ADDR_WIDTH  registered writeback address
- exu_wb_rd_wr_en  output  1  registered write enable
- wb_stall  output  1  some valid source was denied this cycle (combinational)

Behaviour:
- Handshake is valid/ready. A transfer occurs on a cycle with valid & ready. A source holds valid, rd_addr and data stable until that transfer. At most one ready is high per cycle. ready is never high without the matching valid.
- Base priority: LSU > DIV > MUL > ALU.
- Aging: one counter per source, 4 bits.
  - Counter increments, saturating at STARVE_LIMIT, on each cycle the source is valid but not granted.
  - Counter clears on grant or when valid is low.
  - A source whose counter equals STARVE_LIMIT is "starved".
  - Any starved source outranks every non-starved source. Among starved sources, base priority applies.
- Output register, latency 1: the cycle after a transfer, exu_wb_rd_wr_en=1 with the granted rd_addr/data. With no transfer, exu_wb_rd_wr_en=0 and rd_addr/data hold their previous values.
- x0 suppression: a grant with rd_addr==0 completes the handshake but produces exu_wb_rd_wr_en=0.
- wb_stall = OR over sources of (valid & ~ready).
- Reset (rst=1 at a clk edge):
  - exu_wb_rd_wr_en=0, exu_wb_rd_addr=0, exu_wb_data=0, all counters 0.
  - While rst is high, every ready is forced 0 and wb_stall is forced 0.
  - A source asserting valid across reset simply retries after reset; no partial transfer is possible.
- Simultaneous requests to the same rd: the winner is written first and the loser on a later cycle. Ordering correctness is guaranteed by the IDU1 stall scheme, not by this block.
- All sources idle: no ready, wr_en=0, wb_stall=0.
- Single requester is granted in the same cycle, with no bubble. Back-to-back grants to different sources sustain 1 writeback/cycle.

Optional Feature:
- Macro WB_ARB_RR_EN.
  - Defined: base priority becomes rotating round-robin. A last_grant pointer (2 bits, reset to ALU) makes the source after the last granted one highest priority. Aging still overrides the rotation. The pointer advances only on a transfer.
  - Undefined: fixed LSU > DIV > MUL > ALU priority as above, and no pointer state exists.

Test Plan:
- Reset: assert rst 2 cycles with all valids=1 -> all ready=0, wb_stall=0, exu_wb_rd_wr_en=0, exu_wb_rd_addr=0, exu_wb_data=0.
- Single source: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> alu_ready=1 same cycle; next cycle wr_en=1, rd_addr=5, data=0xDEADBEEF; following cycle wr_en=0.
- Contention: mul (rd=3, 0x11) and lsu (rd=4, 0x22) valid together -> lsu granted first, wb_stall=1 that cycle; mul granted next cycle; outputs rd 4 then rd 3 on consecutive cycles.
- Starvation (fixed priority, STARVE_LIMIT=4): alu_valid held, lsu/div issue continuous new requests -> alu denied exactly 4 cycles, granted on the 5th, and its counter clears.
- x0 write: div_valid, rd=0, data=0x55 -> div_ready=1; next cycle wr_en=0.
- WB_ARB_RR_EN defined: all four valid continuously with new data each grant -> grant order MUL, DIV, LSU, ALU, MUL…; wb_stall=1 throughout.
